// File: rtl/mmu_host_rd_router_pkg.sv
// Shared types and constants for the host read ordering router.
package mmu_host_rd_router_pkg;

  localparam int N_REGIONS = 4;
  localparam int LEN_BITS  = 28;
  localparam int VFID_BITS = $clog2(N_REGIONS);

  typedef logic [VFID_BITS-1:0] vfid_t;
  typedef logic [LEN_BITS-1:0]  len_t;
  // One extra bit so rounding up the largest length cannot wrap.
  typedef logic [LEN_BITS:0]    beats_t;

  // One ordering entry: destination region and transfer length in bytes.
  typedef struct packed {
    vfid_t vfid;
    len_t  len;
  } mux_ord_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_XFER
  } rtr_state_t;

  // Round a byte length up to whole beats of 2**shift bytes.
  function automatic beats_t len_to_beats(input len_t len, input int unsigned shift);
    beats_t sum;
    sum = beats_t'(len) + ((beats_t'(1) << shift) - beats_t'(1));
    return sum >> shift;
  endfunction

endpackage

// File: rtl/mmu_host_rd_router_if.sv
// Ordering channel, merged host read stream and per-region output streams.
interface mmu_host_rd_router_if #(
  parameter int DATA_BITS = 512
);
  import mmu_host_rd_router_pkg::*;

  localparam int BEAT_BYTES = DATA_BITS / 8;

  // Ordering entries from the host read arbiter.
  logic                  s_mux_valid;
  logic                  s_mux_ready;
  vfid_t                 s_mux_vfid;
  len_t                  s_mux_len;

  // Merged host read data from the DMA engine.
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_BITS-1:0]  s_axis_tdata;
  logic [BEAT_BYTES-1:0] s_axis_tkeep;
  logic                  s_axis_tlast;

  // Per-region valid/ready over a shared data bus.
  logic [N_REGIONS-1:0]  m_axis_tvalid;
  logic [N_REGIONS-1:0]  m_axis_tready;
  logic [DATA_BITS-1:0]  m_axis_tdata;
  logic [BEAT_BYTES-1:0] m_axis_tkeep;
  logic                  m_axis_tlast;

  // Router side.
  modport slave (
    input  s_mux_valid, s_mux_vfid, s_mux_len,
    output s_mux_ready,
    input  s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    input  m_axis_tready
  );

  // Environment side: drives entries and host data, consumes region streams.
  modport master (
    output s_mux_valid, s_mux_vfid, s_mux_len,
    input  s_mux_ready,
    output s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
    output m_axis_tready
  );

endinterface

// File: rtl/mmu_host_rd_router_queue.sv
// Ordering queue: synchronous FIFO of mux_ord_t with registered full/empty.
module mmu_host_rd_router_queue
  import mmu_host_rd_router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     push,
  input  mux_ord_t                 wr_data,
  input  logic                     pop,
  output mux_ord_t                 rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;

  mux_ord_t                mem [DEPTH];
  logic [PTR_BITS-1:0]     wr_ptr;
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [CNT_BITS-1:0]     count_nxt;
  logic                    do_push;
  logic                    do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    // NOTE: default first so every path assigns count_nxt and no latch is inferred.
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + CNT_BITS'(1);
      2'b01:   count_nxt = count - CNT_BITS'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array.
  always_ff @(posedge aclk) begin
    // NOTE: storage is not reset; pointers and count alone define which slots hold live entries.
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers and flags; full/empty are flops so downstream sees clean outputs.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_BITS'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/mmu_host_rd_router.sv
// Steers the merged host read stream to per-region streams in ordering-entry order.
module mmu_host_rd_router
  import mmu_host_rd_router_pkg::*;
#(
  parameter int DATA_BITS = 512,
  parameter int QDEPTH    = 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  mmu_host_rd_router_if.slave   bus,
  output logic                  err_len,
  output vfid_t                 err_vfid
);

  localparam int BEAT_SHIFT = $clog2(DATA_BITS / 8);
  localparam int CNT_BITS   = $clog2(QDEPTH) + 1;

  rtr_state_t            state_q, state_d;
  vfid_t                 dest_q, dest_d;
  beats_t                beats_left_q, beats_d;

  mux_ord_t              q_head;
  mux_ord_t              q_wr;
  logic                  q_full, q_empty, q_push, q_pop;
  logic [CNT_BITS-1:0]   q_count;
  beats_t                head_beats;

  logic                  s_tready;
  logic [N_REGIONS-1:0]  m_tvalid;
  logic                  m_tlast;
  logic                  last_beat;
  logic                  hs;
  logic                  zero_len_err;
  logic                  tlast_err;

  assign q_push     = bus.s_mux_valid && !q_full;
  assign q_wr       = '{vfid: bus.s_mux_vfid, len: bus.s_mux_len};
  assign head_beats = len_to_beats(q_head.len, BEAT_SHIFT);
  assign last_beat  = (beats_left_q == beats_t'(1));
  assign hs         = (state_q == ST_XFER) && bus.s_axis_tvalid && s_tready;

  mmu_host_rd_router_queue #(.DEPTH(QDEPTH)) u_queue (
    .aclk    (aclk),
    .areset  (areset),
    .push    (q_push),
    .wr_data (q_wr),
    .pop     (q_pop),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  // Next state, head load, steering and mismatch detection.
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    beats_d      = beats_left_q;
    q_pop        = 1'b0;
    s_tready     = 1'b0;
    m_tvalid     = '0;
    m_tlast      = 1'b0;
    zero_len_err = 1'b0;
    tlast_err    = 1'b0;
    case (state_q)
      // IDLE loads the head directly so a fresh entry reaches XFER two cycles
      // after its push; LOAD is the bubble between back-to-back transfers.
      ST_IDLE, ST_LOAD: begin
        if (!q_empty) begin
          if (head_beats == '0) begin
            q_pop        = 1'b1;
            zero_len_err = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            dest_d  = q_head.vfid;
            beats_d = head_beats;
            state_d = ST_XFER;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        s_tready         = bus.m_axis_tready[dest_q];
        m_tvalid[dest_q] = bus.s_axis_tvalid;
        m_tlast          = last_beat;
        if (hs) begin
          beats_d   = beats_left_q - beats_t'(1);
          tlast_err = (bus.s_axis_tlast != last_beat);
          if (last_beat) begin
            q_pop   = 1'b1;
            state_d = (q_count > CNT_BITS'(1) || q_push) ? ST_LOAD : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, current destination and remaining beat count.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      dest_q       <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      beats_left_q <= beats_d;
    end
  end

  // Sticky error flag; err_vfid keeps the region of the first error only.
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_len  <= 1'b0;
      err_vfid <= '0;
    end else if (!err_len) begin
      if (zero_len_err) begin
        err_len  <= 1'b1;
        err_vfid <= q_head.vfid;
      end else if (tlast_err) begin
        err_len  <= 1'b1;
        err_vfid <= dest_q;
      end
    end
  end

  assign bus.s_mux_ready   = !q_full;
  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tvalid = m_tvalid;
  assign bus.m_axis_tlast  = m_tlast;
  assign bus.m_axis_tdata  = bus.s_axis_tdata;
  assign bus.m_axis_tkeep  = bus.s_axis_tkeep;

endmodule

// File: tb/tb_mmu_host_rd_router.sv
// Directed bench for mmu_host_rd_router with a beat scoreboard.
module tb_mmu_host_rd_router;
  import mmu_host_rd_router_pkg::*;

  localparam int DW = 512;
  localparam int BB = DW / 8;

  typedef struct {
    vfid_t         dest;
    logic          last;
    logic [DW-1:0] data;
    logic [BB-1:0] keep;
  } exp_beat_t;

  logic  aclk = 1'b0;
  logic  areset = 1'b1;
  logic  err_len;
  vfid_t err_vfid;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  int    beats_seen = 0;
  exp_beat_t sb[$];

  mmu_host_rd_router_if #(.DATA_BITS(DW)) bus ();

  mmu_host_rd_router #(.DATA_BITS(DW), .QDEPTH(8)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .bus      (bus.slave),
    .err_len  (err_len),
    .err_vfid (err_vfid)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every downstream handshake must match the scoreboard head.
  always @(negedge aclk) begin
    if (!areset && |(bus.m_axis_tvalid & bus.m_axis_tready)) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", DW'(bus.m_axis_tvalid), '0);
      end else begin
        exp_beat_t e;
        logic [N_REGIONS-1:0] oh;
        e = sb.pop_front();
        oh = '0;
        oh[e.dest] = 1'b1;
        check("out_dest", DW'(bus.m_axis_tvalid), DW'(oh));
        check("out_data", bus.m_axis_tdata, e.data);
        check("out_keep", DW'(bus.m_axis_tkeep), DW'(e.keep));
        check("out_last", DW'(bus.m_axis_tlast), DW'(e.last));
        beats_seen++;
      end
    end
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic push_entry(input vfid_t vfid, input len_t len);
    logic ok;
    ok = 1'b0;
    bus.s_mux_valid = 1'b1;
    bus.s_mux_vfid  = vfid;
    bus.s_mux_len   = len;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge aclk);
      ok = bus.s_mux_ready;
      @(posedge aclk);
    end
    check("push_timeout", DW'(ok), DW'(1));
    #1;
    bus.s_mux_valid = 1'b0;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [BB-1:0] k, input logic last_in,
                            input vfid_t exp_dest, input logic exp_last);
    bus.s_axis_tdata  = d;
    bus.s_axis_tkeep  = k;
    bus.s_axis_tlast  = last_in;
    bus.s_axis_tvalid = 1'b1;
    sb.push_back('{dest: exp_dest, last: exp_last, data: d, keep: k});
  endtask

  task automatic wait_hs(output int hs_cyc);
    logic hs;
    hs = 1'b0;
    hs_cyc = -1;
    for (int n = 0; n < 64 && !hs; n++) begin
      @(negedge aclk);
      hs = bus.s_axis_tvalid && bus.s_axis_tready;
      if (hs) hs_cyc = cyc;
      @(posedge aclk);
    end
    check("hs_timeout", DW'(hs), DW'(1));
    #1;
    bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_beat(input logic last_in, input vfid_t exp_dest, input logic exp_last,
                           output int hs_cyc);
    drive_beat(rand_data(), BB'($urandom_range(1, 2**16 - 1)), last_in, exp_dest, exp_last);
    wait_hs(hs_cyc);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    int c;
    int hs_at[8];
    int base;
    logic [DW-1:0] held;

    bus.s_mux_valid   = 1'b0;
    bus.s_mux_vfid    = '0;
    bus.s_mux_len     = '0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tkeep  = '0;
    bus.s_axis_tlast  = 1'b0;
    bus.m_axis_tready = '1;

    // Reset values.
    wait_cycles(3);
    areset = 1'b0;
    @(negedge aclk);
    check("rst_mux_ready",  DW'(bus.s_mux_ready), DW'(1));
    check("rst_s_tready",   DW'(bus.s_axis_tready), DW'(0));
    check("rst_m_tvalid",   DW'(bus.m_axis_tvalid), DW'(0));
    check("rst_m_tlast",    DW'(bus.m_axis_tlast), DW'(0));
    check("rst_err_len",    DW'(err_len), DW'(0));
    check("rst_err_vfid",   DW'(err_vfid), DW'(0));
    @(posedge aclk); #1;

    // Single transfer with latency: region 2, 256 bytes = 4 beats.
    base = beats_seen;
    push_entry(2'd2, 28'd256);
    @(negedge aclk);
    check("lat_load_cycle", DW'(bus.s_axis_tready), DW'(0));
    @(negedge aclk);
    check("lat_xfer_cycle", DW'(bus.s_axis_tready), DW'(1));
    @(posedge aclk); #1;
    for (int i = 0; i < 4; i++) send_beat(i == 3, 2'd2, i == 3, c);
    wait_cycles(2);
    check("single_beats",   DW'(beats_seen - base), DW'(4));
    check("single_sb_empty", DW'(sb.size()), DW'(0));
    check("single_idle",    DW'(bus.s_axis_tready), DW'(0));
    check("single_err",     DW'(err_len), DW'(0));

    // Partial last beat: 65 bytes = 2 beats to region 1.
    base = beats_seen;
    push_entry(2'd1, 28'd65);
    for (int i = 0; i < 2; i++) send_beat(i == 1, 2'd1, i == 1, c);
    wait_cycles(2);
    check("partial_beats", DW'(beats_seen - base), DW'(2));
    check("partial_idle",  DW'(bus.s_axis_tready), DW'(0));

    // Queue full, then ordering and one bubble between transfers.
    for (int i = 0; i < 8; i++) push_entry(vfid_t'(i % 4), 28'd64);
    @(negedge aclk);
    check("full_mux_ready", DW'(bus.s_mux_ready), DW'(0));
    @(posedge aclk); #1;
    base = beats_seen;
    for (int i = 0; i < 8; i++) begin
      send_beat(1'b1, vfid_t'(i % 4), 1'b1, hs_at[i]);
      if (i == 0) check("ready_after_pop", DW'(bus.s_mux_ready), DW'(1));
      if (i > 0) check("bubble_gap", DW'(hs_at[i] - hs_at[i-1]), DW'(2));
    end
    wait_cycles(2);
    check("order_beats", DW'(beats_seen - base), DW'(8));

    // Backpressure on region 3 for ten cycles mid-transfer.
    base = beats_seen;
    push_entry(2'd3, 28'd256);
    send_beat(1'b0, 2'd3, 1'b0, c);
    bus.m_axis_tready = 4'b0111;
    held = rand_data();
    drive_beat(held, '1, 1'b0, 2'd3, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      check("bp_s_tready", DW'(bus.s_axis_tready), DW'(0));
    end
    check("bp_m_tvalid", DW'(bus.m_axis_tvalid), DW'(4'b1000));
    check("bp_held_data", bus.m_axis_tdata, held);
    @(posedge aclk); #1;
    bus.m_axis_tready = '1;
    wait_hs(c);
    send_beat(1'b0, 2'd3, 1'b0, c);
    send_beat(1'b1, 2'd3, 1'b1, c);
    wait_cycles(2);
    check("bp_beats", DW'(beats_seen - base), DW'(4));
    check("bp_sb_empty", DW'(sb.size()), DW'(0));

    // Early input tlast: error flagged, framing follows the length.
    base = beats_seen;
    push_entry(2'd1, 28'd128);
    send_beat(1'b1, 2'd1, 1'b0, c);
    send_beat(1'b0, 2'd1, 1'b1, c);
    wait_cycles(2);
    check("mm_err_len",  DW'(err_len), DW'(1));
    check("mm_err_vfid", DW'(err_vfid), DW'(1));
    check("mm_beats",    DW'(beats_seen - base), DW'(2));

    // Reset in the middle of a transfer flushes everything.
    push_entry(2'd2, 28'd256);
    push_entry(2'd1, 28'd64);
    send_beat(1'b0, 2'd2, 1'b0, c);
    areset = 1'b1;
    @(posedge aclk); #1;
    areset = 1'b0;
    @(negedge aclk);
    check("mid_rst_mux_ready", DW'(bus.s_mux_ready), DW'(1));
    check("mid_rst_s_tready",  DW'(bus.s_axis_tready), DW'(0));
    check("mid_rst_m_tvalid",  DW'(bus.m_axis_tvalid), DW'(0));
    check("mid_rst_m_tlast",   DW'(bus.m_axis_tlast), DW'(0));
    check("mid_rst_err_len",   DW'(err_len), DW'(0));
    check("mid_rst_err_vfid",  DW'(err_vfid), DW'(0));
    wait_cycles(3);
    check("flushed_idle", DW'(bus.s_axis_tready), DW'(0));
    base = beats_seen;
    push_entry(2'd1, 28'd64);
    send_beat(1'b1, 2'd1, 1'b1, c);
    wait_cycles(2);
    check("post_rst_beats", DW'(beats_seen - base), DW'(1));
    check("post_rst_err",   DW'(err_len), DW'(0));

    // Zero length: popped with no beats, error set; next entry still routes.
    push_entry(2'd0, 28'd0);
    wait_cycles(3);
    check("zero_err_len",  DW'(err_len), DW'(1));
    check("zero_err_vfid", DW'(err_vfid), DW'(0));
    check("zero_no_xfer",  DW'(bus.s_axis_tready), DW'(0));
    base = beats_seen;
    push_entry(2'd3, 28'd64);
    send_beat(1'b0, 2'd3, 1'b1, c);
    wait_cycles(2);
    check("after_zero_beats", DW'(beats_seen - base), DW'(1));
    check("sticky_err_vfid",  DW'(err_vfid), DW'(0));
    check("final_sb_empty",   DW'(sb.size()), DW'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmu_host_rd_router.md
# mmu_host_rd_router

Receiving end of the host read ordering channel that the MMU's host read arbiter emits (`m_mux_host_rd`).
- Each ordering entry names a region (`vfid`) and a transfer length in bytes.
- The block queues entries in issue order and steers the merged host read data stream from the XDMA, beat by beat, to the per-region user streams.
- It regenerates `tlast` per transfer and flags length/`tlast` disagreement.
- Sits between the host DMA read data path and the dynamic-region stream crossbar.

## Interface
Parameters:
- `N_REGIONS`, 4: number of dynamic regions (package constant); destination count.
- `DATA_BITS`, 512: stream data width; `BEAT_BYTES = DATA_BITS/8`.
- `LEN_BITS`, 28: ordering-entry length width, in bytes.
- `QDEPTH`, 8: ordering queue depth; power of two, ≥ 2.

Ports:
- `aclk` in 1: clock.
- `areset` in 1: **one clock; reset is synchronous and active-high.**
- `s_mux_valid` in 1: ordering entry valid.
- `s_mux_ready` out 1: ordering entry accept.
- `s_mux_vfid` in `clog2(N_REGIONS)`: destination region.
- `s_mux_len` in `LEN_BITS`: transfer bytes.
- `s_axis_tvalid` in 1: host read data valid.
- `s_axis_tready` out 1: host read data accept.
- `s_axis_tdata` in `DATA_BITS`: host read data.
- `s_axis_tkeep` in `BEAT_BYTES`: host read byte enables.
- `s_axis_tlast` in 1: host read last beat.
- `m_axis_tvalid` out `N_REGIONS`: per-region output valid.
- `m_axis_tready` in `N_REGIONS`: per-region output ready.
- `m_axis_tdata` out `DATA_BITS`: shared output data, qualified by `m_axis_tvalid[i]`.
- `m_axis_tkeep` out `BEAT_BYTES`: shared output byte enables.
- `m_axis_tlast` out 1: shared output last beat.
- `err_len` out 1: sticky error flag; cleared only by reset.
- `err_vfid` out `clog2(N_REGIONS)`: region of the first error.

## Operation
- **Ordering queue:** FIFO of `{vfid, len}`, `QDEPTH` entries.
  - `s_mux_ready = !full`.
  - Push on `s_mux_valid & s_mux_ready`.
- **Head decode:** on load of a head entry, `beats = (len + BEAT_BYTES-1) >> log2(BEAT_BYTES)`.
  - Computed in `LEN_BITS+1` bits; no overflow for `len` = 2^LEN_BITS-1.
  - `len == 0`: entry is popped with zero beats routed; `err_len` is set.
- **FSM states:** IDLE, LOAD, XFER.
  - IDLE → LOAD when the queue is non-empty.
  - LOAD registers `dest`, `beats_left = beats` → XFER. If `beats == 0`, LOAD instead pops the entry and goes → IDLE.
  - XFER: `s_axis_tready = m_axis_tready[dest]`; `m_axis_tvalid[dest] = s_axis_tvalid`; all other `m_axis_tvalid` bits are 0.
    - Data and keep pass through combinationally.
    - `m_axis_tlast = (beats_left == 1)`.
    - Each handshake decrements `beats_left`.
    - On the handshake with `beats_left == 1`: pop the entry; → LOAD if the queue holds another entry, else → IDLE.
- **Mismatch:** in XFER, `s_axis_tlast` must equal `(beats_left == 1)`.
  - On disagreement, set `err_len` and latch `err_vfid = dest`, only if `err_len` was 0.
  - Routing continues on the computed beat count; input `tlast` is ignored for framing.
- **Simultaneous events:**
  - Push and pop in the same cycle are legal when not full.
  - When full, the pop frees a slot visible to `s_mux_ready` on the next cycle.
- **Reset mid-transfer:** queue is flushed and FSM → IDLE; any partial transfer is abandoned.

## Timing
- **Reset values:**
  - `s_mux_ready = 1` (queue empty).
  - `s_axis_tready = 0`; `m_axis_tvalid = 0`; `m_axis_tlast = 0`.
  - `err_len = 0`; `err_vfid = 0`.
  - `m_axis_tdata` / `m_axis_tkeep` are don't-care.
- **Entry-to-data latency:**
  - Entry pushed at cycle t; queue non-empty at t+1; LOAD at t+1; XFER (`s_axis_tready` may rise) at t+2.
  - Back-to-back transfers cost one LOAD bubble cycle between them.
- **Data path:** zero-latency pass-through in XFER. `s_axis_tready` depends combinationally on `m_axis_tready[dest]`; downstream slices break the timing path if needed.
- **Handshakes:** AXI4-Stream rules.
  - Upstream `tvalid` must not drop before handshake.
  - The block never changes `dest` while a beat is pending.

## Structure
- **Shared package:** add `mux_ord_t {vfid, len}` to `lynxTypes`. `N_REGIONS` and `LEN_BITS` already live there.
- **Sub-module:** `mux_ord_queue`, a synchronous FIFO of `mux_ord_t` with `full`/`empty` and registered outputs.
- **Top:** FSM, beat counter, steering and error logic, 150–250 lines total.

## Test plan
- **Single transfer:** entry `{vfid=2, len=256}`, 4 beats with `tlast` on beat 4 → only `m_axis_tvalid[2]` toggles; 4 handshakes; `m_axis_tlast` on the 4th; queue empty; `err_len = 0`.
- **Partial beat:** `{vfid=1, len=65}` → exactly 2 beats routed to region 1; `tlast` on beat 2.
- **Queue full and order:** queue 8 entries for vfids 0,1,2,3,0,1,2,3 with no data → `s_mux_ready = 0` after the 8th. Stream 8×1-beat transfers → destinations follow entry order exactly, one bubble each; `s_mux_ready` returns 1 the cycle after the first pop.
- **Backpressure:** `m_axis_tready[3] = 0` for 10 cycles mid-transfer on region 3 → `s_axis_tready = 0`, data held, no beat lost or duplicated; other regions see `tvalid = 0`.
- **Mismatch:** `{vfid=1, len=128}` with input `tlast` on beat 1 → `err_len = 1`, `err_vfid = 1`, 2 beats still routed.
- **Zero length and reset:** `{vfid=0, len=0}` → popped, no beats, `err_len = 1`. Reset asserted mid-XFER → all reset values next cycle; the next entry routes correctly.
